// File: rtl/nibble_add_seq.sv
// Multi-cycle W-bit add/subtract built around a single 4-bit ripple-carry slice.
// One nibble per clock, LSB first, with a registered carry between nibbles.
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;

    state_t            w_state_nxt;
    logic [W-1:0]      w_a_nxt;
    logic [W-1:0]      w_b_nxt;
    logic              w_carry_nxt;
    logic [IDXW-1:0]   w_idx_nxt;
    logic [W-1:0]      w_sum_nxt;
    logic              w_cout_nxt;
    logic              w_ovf_nxt;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_slice_sum;
    logic              w_slice_c;
    logic [W-1:0]      w_sum_upd;
    logic              w_last;

    assign w_last = (r_idx == IDXW'(NIBBLES - 1));

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < int'(NIBBLES); n++) begin
            if (r_idx == IDXW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    // 4-bit ripple-carry slice; w_slice_c ends as the slice carry-out.
    always_comb begin
        w_slice_sum = 4'd0;
        w_slice_c   = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_slice_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_slice_c;
            w_slice_c      = (w_a_nib[i] & w_b_nib[i]) |
                             (w_slice_c & (w_a_nib[i] ^ w_b_nib[i]));
        end
    end

    // Merge the fresh slice result into the addressed sum nibble.
    always_comb begin
        w_sum_upd = r_sum;
        for (int n = 0; n < int'(NIBBLES); n++) begin
            if (r_idx == IDXW'(n)) begin
                w_sum_upd[4*n +: 4] = w_slice_sum;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_carry_nxt = r_carry;
        w_idx_nxt   = r_idx;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = a;
                    w_b_nxt     = op ? ~b : b;
                    w_carry_nxt = op ? 1'b1 : cin;
                    w_idx_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_cout_nxt  = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sum_nxt   = w_sum_upd;
                w_carry_nxt = w_slice_c;
                if (w_last) begin
                    w_cout_nxt  = w_slice_c;
                    w_ovf_nxt   = (r_a[W-1] == r_b[W-1]) && (w_slice_sum[3] != r_a[W-1]);
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_carry     <= w_carry_nxt;
            r_idx       <= w_idx_nxt;
            r_sum       <= w_sum_nxt;
            r_cout      <= w_cout_nxt;
            r_ovf       <= w_ovf_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq (NIBBLES = 4): directed cases, backpressure,
// mid-operation reset and back-to-back random traffic.
module tb_nibble_add_seq;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } sb_item_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    sb_item_t       sb[$];
    sb_item_t       mon_e;
    logic           prev_ov = 1'b0;
    logic           b2b     = 1'b0;
    int             last_rise = -1;

    nibble_add_seq #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic sb_item_t model(input logic o, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic ci);
        sb_item_t   r;
        logic [W:0] full;
        if (!o) begin
            full  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            r.ovf = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            r.ovf = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end
        r.sum     = full[W-1:0];
        r.cout    = full[W];
        r.acc_cyc = 0;
        return r;
    endfunction

    // Present one request and wait (bounded) until it is accepted.
    task automatic drive(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        sb_item_t e;
        int       w;
        @(negedge clk);
        op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e         = model(o, x, y, ci);
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int w;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while ((sb.size() != 0 || !in_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || !in_ready) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Compare each new result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("sum",     32'(sum),  32'(mon_e.sum));
                check_eq("cout",    32'(cout), 32'(mon_e.cout));
                check_eq("ovf",     32'(ovf),  32'(mon_e.ovf));
                check_eq("latency", 32'(cyc - mon_e.acc_cyc), 32'(NIB));
                if (b2b && last_rise >= 0) check_eq("b2b_period", 32'(cyc - last_rise), 32'(NIB + 2));
                last_rise = cyc;
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum",       32'(sum),       32'd0);
        check_eq("rst_cout",      32'(cout),      32'd0);
        check_eq("rst_ovf",       32'(ovf),       32'd0);

        // Directed add / subtract cases.
        drive(1'b0, 16'h1234, 16'h0FFF, 1'b0); wait_drain();
        drive(1'b0, 16'hFFFF, 16'h0000, 1'b1); wait_drain();
        drive(1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_drain();
        drive(1'b1, 16'h0005, 16'h0007, 1'b1); wait_drain();
        drive(1'b1, 16'h8000, 16'h0001, 1'b0); wait_drain();

        // Backpressure: result held while a competing request waits.
        out_ready = 1'b0;
        drive(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_out_valid_seen", 32'(out_valid), 32'd1);
        op = 1'b1; a = 16'h0100; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(in_ready),  32'd0);
            check_eq("bp_hold_sum",   32'(sum),       32'h3333);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 32'(in_ready),  32'd1);
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        begin
            sb_item_t e;
            e         = model(1'b1, 16'h0100, 16'h0001, 1'b0);
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        wait_drain();

        // Reset during the second RUN cycle aborts the operation.
        drive(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check_eq("abort_in_ready",  32'(in_ready),  32'd1);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_sum",       32'(sum),       32'd0);
        drive(1'b0, 16'h0001, 16'h0001, 1'b0); wait_drain();

        // Back-to-back random traffic with both handshakes held high.
        b2b = 1'b1;
        last_rise = -1;
        for (int k = 0; k < 32; k++) begin
            drive(k >= 16, W'($urandom), W'($urandom), 1'($urandom));
        end
        wait_drain();
        b2b = 1'b0;

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle sequencer that performs W-bit add/subtract using a single internal 4-bit ripple-carry adder slice, one nibble per clock from LSB to MSB, with a registered carry chain between nibbles. It sits between a requester that issues operand pairs over a valid/ready handshake and a consumer that takes the result over a second valid/ready handshake. It trades latency for area where a full-width adder is not justified.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  requester presents op, a, b, cin.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  1  0 = add (a + b + cin), 1 = subtract (a − b, cin ignored).
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in for add.
- out_valid  out  1  result registers valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- sum  out  W  result.
- cout  out  1  carry out of MSB nibble (subtract: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready = 1. On in_valid at an edge: capture a; capture b (inverted when op = 1); carry register ← cin (add) or 1 (subtract); nibble index ← 0; → RUN.
- RUN: each cycle the slice adds nibble[idx] of captured A and B with carry register; result nibble written to sum[4*idx+3:4*idx]; carry register ← slice carry-out; idx increments. On idx = NIBBLES−1: cout ← slice carry-out; ovf ← (A[W−1] == B'[W−1]) && (result MSB != A[W−1]), where B' is the captured (possibly inverted) operand; → DONE.
- DONE: out_valid = 1; sum, cout, ovf stable. On out_ready at an edge → IDLE. in_valid ignored.
- in_valid in RUN or DONE is not accepted and produces no side effect; requester must hold it until in_ready.
- Inputs a, b, op, cin sampled only at the accepting edge; later changes have no effect.
- sum is cleared to 0 at acceptance; partially written nibbles are visible during RUN, not valid until out_valid.
- Width rules: all arithmetic modulo 2^W; no saturation.
- Reset outputs: in_ready = 1 (IDLE), out_valid = 0, sum = 0, cout = 0, ovf = 0; carry register and index = 0.
- Reset mid-RUN or mid-DONE: operation aborted, result discarded, reset values next cycle; no out_valid for the aborted operation.

## Timing
- Accept at edge k (in_valid & in_ready); RUN during cycles k+1 … k+NIBBLES; out_valid high from edge k+NIBBLES.
- Latency accept → out_valid = NIBBLES cycles; NIBBLES = 1 gives 1 cycle.
- out_ready & out_valid at edge m → out_valid low, in_ready high after edge m; next accept earliest at edge m+1.
- Throughput (out_ready held high): one result per NIBBLES+2 cycles.
- out_ready while not in DONE ignored.
- in_ready and out_valid are pure state decodes (registered, no combinational path from inputs).

## Test plan
- Reset then add, NIBBLES=4: a=0x1234, b=0x0FFF, cin=0 → after 4 cycles out_valid=1, sum=0x2233, cout=0, ovf=0.
- Carry wrap: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract: op=1, a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs stable, in_ready=0, second in_valid with different operands not accepted; out_ready high → next accept one cycle after release, correct second result.
- Reset mid-operation: assert rst on second RUN cycle → next cycle in_ready=1, out_valid=0, sum=0; subsequent 0x0001+0x0001 → 0x0002 with correct 4-cycle latency.
- Back-to-back with out_ready tied high and in_valid tied high: 16 random operand pairs per op → every result matches a W-bit reference model; out_valid pulses every 6 cycles.
